wdg_reset_ctrl: RTL and testbench
=================================

// Module: wdg_reset_ctrl
// PURPOSE
//  Reset/interrupt controller directly downstream of WWDG and IWDG. Consumes wwdg_rst, iwdg_rst and wwdg_ewi.
//  Drives a stretched system reset (sys_rst) and a maskable early-wakeup interrupt (irq).
//  Keeps sticky reset-cause flags and accepts a keyed software-reset request.
//  Wishbone-style slave on the same bus as WWDG; survives sys_rst (reset only by rst).
// PARAMETERS
//  DAT_SIZE    10                 bus data width (bits [7:0] used, upper bits read 0)
//  RST_PULSE   16                 sys_rst stretch length in clk cycles (>=1)
//  BASE_ADR    32'h0110_0100      register block base
//  CSR_ADR     BASE_ADR+32'h0     reset-cause status/clear
//  IRQ_ADR     BASE_ADR+32'h4     EWI flag/enable
//  SWR_ADR     BASE_ADR+32'h8     software reset key
// PORTS
//  clk       in   1         single clock, all logic on rising edge
//  rst       in   1         synchronous, active-high power-on reset
//  dat_m2s   in   DAT_SIZE  write data
//  adr_m2s   in   32        address
//  cyc_m2s   in   1         bus cycle
//  we_m2s    in   1         1=write 0=read
//  stb_m2s   in   1         strobe
//  dat_s2m   out  DAT_SIZE  read data
//  ack_s2m   out  1         transfer acknowledge
//  wwdg_rst  in   1         WWDG reset request (level)
//  iwdg_rst  in   1         IWDG reset request (level)
//  wwdg_ewi  in   1         WWDG early-wakeup (rising edge counts)
//  sys_rst   out  1         stretched system reset
//  irq       out  1         EWIF & EWIE
// BEHAVIOUR
//  Reset (rst=1): ack_s2m=0, dat_s2m=0, irq=0, EWIF=EWIE=0, flags=4'b1000 (PORRSTF), cnt<=RST_PULSE.
//    sys_rst=1 during rst and for RST_PULSE cycles after release.
//  Bus handshake:
//    - Registered ack, one cycle after cyc&stb sampled; exactly one cycle high.
//    - No new ack while ack_s2m=1.
//    - Write takes effect on the edge that raises ack.
//    - dat_s2m valid while ack=1, else 0.
//    - Unmapped address: ack given, read 0, write ignored.
//  CSR: [0] WWDGRSTF [1] IWDGRSTF [2] SFTRSTF [3] PORRSTF, read-only.
//    - Write with bit7 (RMVF)=1 clears [3:0]. RMVF reads 0.
//    - A source active in the same cycle as RMVF: its flag sets (set wins).
//  IRQ: [0] EWIF, set on wwdg_ewi rising edge, write-1-to-clear. [1] EWIE, read/write.
//    - EWIF set and clear in the same cycle: set wins.
//    - EWIF and EWIE are held 0 while sys_rst=1.
//    - irq is registered: high the cycle after EWIF&EWIE becomes true.
//  SWR: write with dat_m2s[7:0]==8'hA5 raises a one-cycle sw_req. Any other value is ignored.
//  Stretch counter, width $clog2(RST_PULSE+1):
//    - Any of wwdg_rst/iwdg_src/sw_req sampled high: cnt<=RST_PULSE and the matching flag is set.
//    - Else if cnt!=0: cnt<=cnt-1.
//    - sys_rst = (cnt!=0), so it rises 1 cycle after source and falls RST_PULSE cycles after the last active cycle.
//    - A new source during stretch reloads cnt (no wrap, no early release).
//    - Simultaneous sources set all matching flags.
//  rst mid-stretch: counter reloads to RST_PULSE; flags become 4'b1000.
// CONFIGURATION
//  WDG_RST_SYNC_EN defined: iwdg_rst passes a 2-flop synchronizer (iwdg_src = sync output).
//    IWDG path latency to sys_rst is 3 cycles.
//  WDG_RST_SYNC_EN undefined: iwdg_src = iwdg_rst, latency 1 cycle like wwdg_rst.
//  Synchronizer flops reset to 0.
// TESTING
//  1. rst 2 cycles, release -> sys_rst=1 exactly 16 more cycles, then 0; read CSR -> 0x008.
//  2. write CSR 0x080 -> ack 1 cycle later; read CSR -> 0x000.
//  3. wwdg_rst 1-cycle pulse -> sys_rst=1 next cycle for 16 cycles; CSR -> 0x001; IRQ reads 0x000.
//  4. write IRQ 0x002, pulse wwdg_ewi -> irq=1; IRQ -> 0x003; write IRQ 0x003 -> irq=0, IRQ -> 0x002.
//  5. write SWR 0x0A4 -> no sys_rst; write SWR 0x0A5 -> sys_rst 16 cycles, CSR bit2=1; read 0x0110_01FC -> 0, ack.
//  6. iwdg_rst high -> sys_rst after 3 cycles with WDG_RST_SYNC_EN, 1 without; CSR bit1=1; repulse mid-stretch reloads.

Source files
------------

// File: rtl/wdg_reset_ctrl.sv
// Reset/interrupt controller behind WWDG/IWDG: stretched sys_rst, sticky cause flags, EWI irq, keyed SW reset.
// Optional macro WDG_RST_SYNC_EN adds a 2-flop synchronizer on iwdg_rst.
`timescale 1ns/1ps
module wdg_reset_ctrl #(
    parameter int          DAT_SIZE  = 10,
    parameter int          RST_PULSE = 16,
    parameter logic [31:0] BASE_ADR  = 32'h0110_0100,
    parameter logic [31:0] CSR_ADR   = BASE_ADR + 32'h0,
    parameter logic [31:0] IRQ_ADR   = BASE_ADR + 32'h4,
    parameter logic [31:0] SWR_ADR   = BASE_ADR + 32'h8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DAT_SIZE-1:0] dat_m2s,
    input  logic [31:0]         adr_m2s,
    input  logic                cyc_m2s,
    input  logic                we_m2s,
    input  logic                stb_m2s,
    output logic [DAT_SIZE-1:0] dat_s2m,
    output logic                ack_s2m,
    input  logic                wwdg_rst,
    input  logic                iwdg_rst,
    input  logic                wwdg_ewi,
    output logic                sys_rst,
    output logic                irq
);
    localparam int               CNT_W    = $clog2(RST_PULSE + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_PULSE);

    logic [CNT_W-1:0]    cnt;
    logic [3:0]          flags;
    logic                ewif, ewie, ewi_prev, sw_req;
    logic                iwdg_src;
    logic                access, wr, sel_csr, sel_irq, sel_swr;
    logic                src_any, ewi_rise;
    logic [DAT_SIZE-1:0] rd_data;
    logic                unused_dat_hi;

`ifdef WDG_RST_SYNC_EN
    logic iwdg_sync_p0, iwdg_sync_p1;

    // iwdg_rst comes from another clock domain: two-stage synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            iwdg_sync_p0 <= 1'b0;
            iwdg_sync_p1 <= 1'b0;
        end else begin
            iwdg_sync_p0 <= iwdg_rst;
            iwdg_sync_p1 <= iwdg_sync_p0;
        end
    end
    assign iwdg_src = iwdg_sync_p1;
`else
    assign iwdg_src = iwdg_rst;
`endif

    assign unused_dat_hi = ^dat_m2s[DAT_SIZE-1:8];

    assign access   = cyc_m2s & stb_m2s & ~ack_s2m;
    assign wr       = access & we_m2s;
    assign sel_csr  = (adr_m2s == CSR_ADR);
    assign sel_irq  = (adr_m2s == IRQ_ADR);
    assign sel_swr  = (adr_m2s == SWR_ADR);
    assign src_any  = wwdg_rst | iwdg_src | sw_req;
    assign ewi_rise = wwdg_ewi & ~ewi_prev;
    assign sys_rst  = (cnt != '0);

    always_comb begin
        rd_data = '0;
        if (sel_csr)
            rd_data[3:0] = flags;
        else if (sel_irq)
            rd_data[1:0] = {ewie, ewif};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_s2m  <= 1'b0;
            dat_s2m  <= '0;
            irq      <= 1'b0;
            ewif     <= 1'b0;
            ewie     <= 1'b0;
            ewi_prev <= 1'b0;
            sw_req   <= 1'b0;
            flags    <= 4'b1000;
            cnt      <= CNT_LOAD;
        end else begin
            ack_s2m  <= access;
            dat_s2m  <= (access & ~we_m2s) ? rd_data : '0;
            ewi_prev <= wwdg_ewi;
            sw_req   <= wr & sel_swr & (dat_m2s[7:0] == 8'hA5);
            irq      <= ewif & ewie;
            // RMVF clears first, so a source in the same cycle still leaves its flag set
            flags    <= ((wr & sel_csr & dat_m2s[7]) ? 4'b0000 : flags)
                        | {1'b0, sw_req, iwdg_src, wwdg_rst};
            if (src_any)
                cnt <= CNT_LOAD;
            else if (sys_rst)
                cnt <= cnt - CNT_W'(1);
            if (sys_rst) begin
                ewif <= 1'b0;
                ewie <= 1'b0;
            end else begin
                if (ewi_rise)
                    ewif <= 1'b1;
                else if (wr & sel_irq & dat_m2s[0])
                    ewif <= 1'b0;
                if (wr & sel_irq)
                    ewie <= dat_m2s[1];
            end
        end
    end
endmodule

// File: tb/tb_wdg_reset_ctrl.sv
// Scoreboard bench for wdg_reset_ctrl: directed scenarios then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_wdg_reset_ctrl;
    localparam int          DAT_SIZE  = 10;
    localparam int          RST_PULSE = 16;
    localparam logic [31:0] CSR = 32'h0110_0100;
    localparam logic [31:0] IRQ = 32'h0110_0104;
    localparam logic [31:0] SWR = 32'h0110_0108;
    localparam logic [31:0] BAD = 32'h0110_01FC;
`ifdef WDG_RST_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [DAT_SIZE-1:0] dat_m2s = '0;
    logic [31:0]         adr_m2s = '0;
    logic                cyc_m2s = 1'b0, we_m2s = 1'b0, stb_m2s = 1'b0;
    logic [DAT_SIZE-1:0] dat_s2m;
    logic                ack_s2m;
    logic                wwdg_rst = 1'b0, iwdg_rst = 1'b0, wwdg_ewi = 1'b0;
    logic                sys_rst, irq;

    wdg_reset_ctrl dut (
        .clk(clk), .rst(rst), .dat_m2s(dat_m2s), .adr_m2s(adr_m2s),
        .cyc_m2s(cyc_m2s), .we_m2s(we_m2s), .stb_m2s(stb_m2s),
        .dat_s2m(dat_s2m), .ack_s2m(ack_s2m),
        .wwdg_rst(wwdg_rst), .iwdg_rst(iwdg_rst), .wwdg_ewi(wwdg_ewi),
        .sys_rst(sys_rst), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        bit                  rd;
        logic [DAT_SIZE-1:0] val;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: sys_rst is "fewer than RST_PULSE edges since the last reset source"
    int       m_age = 100000;
    bit       m_started = 0;
    bit [3:0] m_flags;
    bit       m_ewif, m_ewie, m_irq, m_ack, m_ewi_prev, m_swreq, iw_d1, iw_d2;

    always @(posedge clk) begin
        bit       sr, iw_src, acc, wr, any, rise;
        bit [3:0] nf;
        exp_t     e;
        sr = (m_age < RST_PULSE);
        if (rst) begin
            m_age = 0; m_flags = 4'b1000; m_ewif = 0; m_ewie = 0; m_irq = 0;
            m_ack = 0; m_ewi_prev = 0; m_swreq = 0; iw_d1 = 0; iw_d2 = 0;
            m_started = 1;
        end else begin
            iw_src = SYNC ? iw_d2 : iwdg_rst;
            any    = wwdg_rst | iw_src | m_swreq;
            acc    = cyc_m2s && stb_m2s && !m_ack;
            wr     = acc && we_m2s;
            rise   = wwdg_ewi && !m_ewi_prev;
            if (acc) begin
                e.rd  = !we_m2s;
                e.val = '0;
                if (adr_m2s == CSR) e.val = DAT_SIZE'(m_flags);
                else if (adr_m2s == IRQ) e.val = DAT_SIZE'({m_ewie, m_ewif});
                exp_q.push_back(e);
            end
            nf = m_flags;
            if (wr && adr_m2s == CSR && dat_m2s[7]) nf = 4'b0000;
            if (wwdg_rst) nf[0] = 1;
            if (iw_src)   nf[1] = 1;
            if (m_swreq)  nf[2] = 1;
            m_flags = nf;
            m_irq = m_ewif && m_ewie;
            if (sr) begin
                m_ewif = 0; m_ewie = 0;
            end else begin
                if (wr && adr_m2s == IRQ) begin
                    if (dat_m2s[0]) m_ewif = 0;
                    m_ewie = dat_m2s[1];
                end
                if (rise) m_ewif = 1;
            end
            m_swreq = wr && adr_m2s == SWR && dat_m2s[7:0] == 8'hA5;
            iw_d2 = iw_d1;
            iw_d1 = iwdg_rst;
            if (any) m_age = 0;
            else if (m_age < 100000) m_age++;
            m_ack = acc;
            m_ewi_prev = wwdg_ewi;
        end
    end

    // Monitor: outputs sampled on the falling edge, read data popped from the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (m_started) begin
            chk("sys_rst", sys_rst, m_age < RST_PULSE);
            chk("irq", irq, m_irq);
            chk("ack_s2m", ack_s2m, m_ack);
            if (ack_s2m) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (e.rd) chk("rd_data", dat_s2m, e.val);
                end
            end else begin
                chk("dat_idle", dat_s2m, 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bus(input bit w, input logic [31:0] a, input logic [DAT_SIZE-1:0] d);
        int waited;
        cyc_m2s = 1; stb_m2s = 1; we_m2s = w; adr_m2s = a; dat_m2s = d;
        step(1);
        cyc_m2s = 0; stb_m2s = 0; we_m2s = 0;
        waited = 0;
        while (!ack_s2m && waited < 8) begin step(1); waited++; end
        if (!ack_s2m) chk("bus_timeout", waited, 0);
        step(1);
    endtask

    initial begin
        int cnt, lat;
        // 1: power-on reset and stretch length
        step(2);
        rst = 0;
        cnt = 0;
        repeat (RST_PULSE + 4) begin @(negedge clk); if (sys_rst) cnt++; end
        #2;
        chk("por_stretch_len", cnt, RST_PULSE);
        bus(0, CSR, 0);
        // 2: remove flags
        bus(1, CSR, 10'h080);
        bus(0, CSR, 0);
        // 3: WWDG reset pulse
        wwdg_rst = 1; step(1); wwdg_rst = 0;
        cnt = 0;
        repeat (RST_PULSE + 4) begin @(negedge clk); if (sys_rst) cnt++; end
        #2;
        chk("wwdg_stretch_len", cnt, RST_PULSE);
        bus(0, CSR, 0);
        bus(0, IRQ, 0);
        // 4: early-wakeup interrupt
        bus(1, IRQ, 10'h002);
        wwdg_ewi = 1; step(1); wwdg_ewi = 0; step(3);
        bus(0, IRQ, 0);
        bus(1, IRQ, 10'h003);
        step(2);
        bus(0, IRQ, 0);
        // 5: software reset key
        bus(1, SWR, 10'h0A4);
        step(4);
        bus(1, SWR, 10'h0A5);
        step(RST_PULSE + 4);
        bus(0, CSR, 0);
        bus(0, BAD, 0);
        bus(1, BAD, 10'h3FF);
        // 6: IWDG latency and reload mid-stretch
        bus(1, CSR, 10'h080);
        iwdg_rst = 1; step(1); iwdg_rst = 0;
        lat = 1;
        while (!sys_rst && lat < 8) begin step(1); lat++; end
        chk("iwdg_latency", lat, SYNC ? 3 : 1);
        step(8);
        iwdg_rst = 1; step(1); iwdg_rst = 0;
        step(RST_PULSE + 6);
        bus(0, CSR, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            rst      = ($urandom_range(0, 299) == 0);
            wwdg_rst = ($urandom_range(0, 39) == 0);
            iwdg_rst = ($urandom_range(0, 39) == 0);
            wwdg_ewi = ($urandom_range(0, 3) == 0);
            cyc_m2s  = ($urandom_range(0, 2) != 0);
            stb_m2s  = ($urandom_range(0, 2) != 0);
            we_m2s   = $urandom_range(0, 1);
            sel = $urandom_range(0, 3);
            adr_m2s = (sel == 0) ? CSR : (sel == 1) ? IRQ : (sel == 2) ? SWR : BAD;
            sel = $urandom_range(0, 5);
            dat_m2s = (sel == 0) ? 10'h080 : (sel == 1) ? 10'h0A5 : (sel == 2) ? 10'h003 :
                      (sel == 3) ? 10'h002 : (sel == 4) ? 10'h001 : DAT_SIZE'($urandom_range(0, 1023));
            step(1);
        end
        rst = 0; wwdg_rst = 0; iwdg_rst = 0; wwdg_ewi = 0;
        cyc_m2s = 0; stb_m2s = 0; we_m2s = 0;
        step(RST_PULSE + 6);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
